if_id_queue: RTL and testbench

Instruction queue between instruction fetch (PC register + instruction memory) and decode. Captures each fetched {PC, Instr} pair in a small FIFO and presents it to decode with a valid/ready handshake. Back-pressures fetch when full, so the PC register can hold. Supports a single-cycle flush for branch/jump redirects.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/if_id_queue_mem.sv | 18 +
 rtl/if_id_queue.sv | 54 +++++
 tb/tb_if_id_queue.sv | 132 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, NOP encoding and the fetch/decode queue entry.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } entry_t;
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH-entry register array, one write port and a combinational read port.
module if_id_queue_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);
  entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: fetch-to-decode FIFO of {pc, instr} with valid/ready handshake and flush.
module if_id_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = riscv_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     f_valid,
  input  logic [XLEN-1:0]          f_pc,
  input  logic [XLEN-1:0]          f_instr,
  output logic                     f_ready,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [XLEN-1:0]          d_pc,
  output logic [XLEN-1:0]          d_instr,
  output logic                     d_misalign,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wp, rp;
  logic push, pop;
  entry_t wdata, head;
  assign f_ready = count != CW'(DEPTH);
  assign d_valid = count != '0;
  assign push = f_valid && f_ready && !flush;
  assign pop  = d_valid && d_ready && !flush;
  assign wdata = '{pc: f_pc, instr: f_instr, misalign: |f_pc[1:0]};
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk)
    if (!rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  if_id_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wp),
    .wdata(wdata),
    .raddr(rp),
    .rdata(head)
  );
  assign d_pc       = d_valid ? head.pc : '0;
  assign d_instr    = d_valid ? head.instr : NOP_INSTR;
  assign d_misalign = d_valid && head.misalign;
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  logic clk = 0, rst = 0, flush = 0, f_valid = 0, d_ready = 0;
  logic [31:0] f_pc = 0, f_instr = 0;
  logic f_ready, d_valid, d_misalign;
  logic [31:0] d_pc, d_instr;
  logic [2:0] count;
  int tests = 0, fails = 0;
  ent_t q[$];
  always #5 clk = ~clk;
  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .f_valid(f_valid), .f_pc(f_pc),
    .f_instr(f_instr), .f_ready(f_ready), .d_valid(d_valid), .d_ready(d_ready),
    .d_pc(d_pc), .d_instr(d_instr), .d_misalign(d_misalign), .count(count)
  );
  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic dr, input logic fl, input logic r);
    bit pu, po;
    f_valid = fv; f_pc = pc; f_instr = ins; d_ready = dr; flush = fl; rst = r;
    @(posedge clk);
    pu = fv && q.size() != DEPTH;
    po = q.size() != 0 && dr;
    if (!r || fl) q.delete();
    else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back('{pc, ins});
    end
    #1;
  endtask
  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (d_valid !== 1'b0) begin fails++; $display("FAIL reset_d_valid got %b exp 0", d_valid); end
    tests++; if (f_ready !== 1'b1) begin fails++; $display("FAIL reset_f_ready got %b exp 1", f_ready); end
    tests++; if (d_instr !== 32'h13) begin fails++; $display("FAIL reset_d_instr got %h exp 00000013", d_instr); end
    tests++; if (d_pc !== 32'h0 || d_misalign !== 1'b0) begin fails++; $display("FAIL reset_d_pc got %h/%b exp 0/0", d_pc, d_misalign); end
  endtask
  task automatic test_fill();
    logic [31:0] ins [4];
    ins = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00000013};
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), ins[i], 0, 0, 1);
    tests++; if (count !== 3'd4 || f_ready !== 1'b0) begin fails++; $display("FAIL fill_full got count=%0d f_ready=%b exp 4/0", count, f_ready); end
    step(1, 16, 32'hdead_beef, 0, 0, 1);
    tests++; if (count !== 3'd4 || d_pc !== 32'h0) begin fails++; $display("FAIL fill_reject got count=%0d d_pc=%h exp 4/0", count, d_pc); end
    step(1, 16, 32'hdead_beef, 1, 0, 1);
    tests++; if (count !== 3'd3 || f_ready !== 1'b1) begin fails++; $display("FAIL full_pop got count=%0d f_ready=%b exp 3/1", count, f_ready); end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (d_pc !== 32'(i * 4) || d_instr !== ins[i] || d_valid !== 1'b1) begin
        fails++; $display("FAIL drain_%0d got pc=%h instr=%h exp pc=%h instr=%h", i, d_pc, d_instr, i * 4, ins[i]);
      end
      step(0, 0, 0, 1, 0, 1);
    end
    tests++; if (d_valid !== 1'b0 || d_instr !== 32'h13) begin fails++; $display("FAIL drain_empty got d_valid=%b instr=%h exp 0/00000013", d_valid, d_instr); end
  endtask
  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(i * 4), 32'(i) ^ 32'h1234_5600, 1, 0, 1);
      tests++;
      if (count !== 3'd1 || d_pc !== 32'(i * 4) || d_instr !== (32'(i) ^ 32'h1234_5600)) begin
        fails++; $display("FAIL stream_%0d got count=%0d pc=%h instr=%h exp 1/%h", i, count, d_pc, d_instr, i * 4);
      end
    end
    step(0, 0, 0, 1, 0, 1);
  endtask
  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1, 32'h10 + 32'(i * 4), 32'h100 + 32'(i), 0, 0, 1);
    step(1, 32'h40, 32'h40, 1, 1, 1);
    tests++;
    if (count !== 3'd0 || d_valid !== 1'b0 || f_ready !== 1'b1 || d_instr !== 32'h13) begin
      fails++; $display("FAIL flush_empty got count=%0d d_valid=%b f_ready=%b instr=%h exp 0/0/1/00000013", count, d_valid, f_ready, d_instr);
    end
    step(1, 32'h80, 32'h0080_0093, 0, 0, 1);
    tests++;
    if (d_pc !== 32'h80 || count !== 3'd1) begin fails++; $display("FAIL flush_refill got pc=%h count=%0d exp 80/1", d_pc, count); end
    step(0, 0, 0, 1, 0, 1);
  endtask
  task automatic test_misalign();
    step(1, 32'h102, 32'h13, 0, 0, 1);
    tests++; if (d_misalign !== 1'b1 || d_pc !== 32'h102) begin fails++; $display("FAIL misalign_set got %b pc=%h exp 1/102", d_misalign, d_pc); end
    step(1, 32'h104, 32'h13, 1, 0, 1);
    tests++; if (d_misalign !== 1'b0 || d_pc !== 32'h104) begin fails++; $display("FAIL misalign_clr got %b pc=%h exp 0/104", d_misalign, d_pc); end
    step(0, 0, 0, 1, 0, 1);
  endtask
  task automatic test_reset_mid();
    step(1, 32'h200, 32'haaaa, 0, 0, 1);
    step(1, 32'h204, 32'hbbbb, 0, 0, 1);
    step(1, 32'h208, 32'hcccc, 1, 0, 0);
    tests++;
    if (count !== 3'd0 || d_valid !== 1'b0 || f_ready !== 1'b1 || d_instr !== 32'h13 || d_pc !== 32'h0) begin
      fails++; $display("FAIL midreset got count=%0d d_valid=%b f_ready=%b pc=%h instr=%h", count, d_valid, f_ready, d_pc, d_instr);
    end
    step(0, 0, 0, 0, 0, 1);
    tests++; if (d_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL midreset_stale got d_valid=%b count=%0d exp 0/0", d_valid, count); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      logic [31:0] epc, ein;
      pc = $urandom;
      step(1'($urandom_range(0, 3) != 0), pc, $urandom, 1'($urandom_range(0, 2) != 0),
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
      epc = q.size() != 0 ? q[0].pc : 32'h0;
      ein = q.size() != 0 ? q[0].instr : 32'h13;
      tests++;
      if (count !== 3'(q.size()) || d_valid !== (q.size() != 0) || f_ready !== (q.size() != DEPTH) ||
          d_pc !== epc || d_instr !== ein || d_misalign !== (epc[1:0] != 2'b0)) begin
        fails++;
        $display("FAIL random_%0d got count=%0d v=%b r=%b pc=%h instr=%h m=%b exp count=%0d pc=%h instr=%h",
                 i, count, d_valid, f_ready, d_pc, d_instr, d_misalign, q.size(), epc, ein);
      end
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_flush();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
